// File: rtl/fwd_hazard_if.sv
// ID-stage request / EX-stage control bundle for the forwarding and hazard controller.
// Perf counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush_in;
  logic              hold_in;
  logic [1:0]        SelFwA;
  logic [1:0]        SelFwB;
  logic              ex_valid;
  logic              stall_id;
  logic              bubble_ex;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;
`endif

  if (REG_AW == 0 || CNT_W == 0) begin : g_bad_param
    $error("fwd_hazard_if: widths must be nonzero");
  end

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush_in, hold_in,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  SelFwA, SelFwB, ex_valid, stall_id, bubble_ex
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write,
           id_mem_read, flush_in, hold_in,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, fwd_cnt,
`endif
    output SelFwA, SelFwB, ex_valid, stall_id, bubble_ex
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use hazard controller tracking EX/MEM/WB dest tags.
// Define HAZ_PERF_CNT_EN to add saturating stall/forward performance counters.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input logic         clk,
  input logic         rst_n,
  fwd_hazard_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } tag_t;

  tag_t       ex_q, mem_q, wb_q, id_tag;
  logic [1:0] sel_a_q, sel_b_q, sel_a, sel_b;
  logic       ex_valid_q;
  logic       load_use, stall, bubble;

  function automatic logic is_zero(logic [REG_AW-1:0] r);
    return ZERO_REG && (r == '0);
  endfunction

  function automatic logic match(tag_t t, logic [REG_AW-1:0] rs);
    return t.v && (t.rd == rs) && !is_zero(rs);
  endfunction

  // Nearest producer wins; a load still in EX cannot forward (load-use stalls instead).
  function automatic logic [1:0] fwd_sel(logic use_rs, logic [REG_AW-1:0] rs,
                                         tag_t ex, tag_t mem, tag_t wb);
    logic [1:0] s;
    s = 2'd0;
    if (use_rs) begin
      if (match(ex, rs) && !ex.ld) s = 2'd1;
      else if (match(mem, rs))     s = 2'd2;
      else if (match(wb, rs))      s = 2'd3;
    end
    return s;
  endfunction

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("fwd_hazard_ctrl: CNT_W must be nonzero");
  end

  always_comb begin
    id_tag    = '0;
    id_tag.v  = bus.id_valid && bus.id_reg_write && !is_zero(bus.id_rd);
    id_tag.rd = bus.id_rd;
    id_tag.ld = bus.id_mem_read;

    load_use = bus.id_valid && ex_q.ld &&
               ((bus.id_use_rs1 && match(ex_q, bus.id_rs1)) ||
                (bus.id_use_rs2 && match(ex_q, bus.id_rs2)));
    stall    = bus.hold_in || (load_use && !bus.flush_in);
    bubble   = !bus.hold_in && (bus.flush_in || load_use || !bus.id_valid);

    sel_a = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_q, mem_q, wb_q);
    sel_b = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_q, mem_q, wb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      sel_a_q    <= 2'd0;
      sel_b_q    <= 2'd0;
      ex_valid_q <= 1'b0;
    end else if (!bus.hold_in) begin
      wb_q       <= mem_q;
      mem_q      <= ex_q;
      ex_q       <= bubble ? '0 : id_tag;
      sel_a_q    <= bubble ? 2'd0 : sel_a;
      sel_b_q    <= bubble ? 2'd0 : sel_b;
      ex_valid_q <= !bubble;
    end
  end

  assign bus.SelFwA    = sel_a_q;
  assign bus.SelFwB    = sel_b_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.stall_id  = stall;
  assign bus.bubble_ex = bubble;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!bus.hold_in) begin
      if (load_use && !bus.flush_in && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!bubble && ((sel_a != 2'd0) || (sel_b != 2'd0)) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Table-driven bench for fwd_hazard_ctrl: combinational outputs checked in-cycle, registered
// selects checked one edge later through an expected-value queue.
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_AW(5), .CNT_W(32)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, fl, hd;
    logic       stall, bubble;
    logic [1:0] a, b;
    logic       exv;
  } vec_t;

  typedef struct packed {
    logic [1:0] a, b;
    logic       exv;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_stall_cnt = 0;
  int   exp_fwd_cnt   = 0;

  function automatic vec_t mk(logic valid, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic fl, logic hd,
                              logic stall, logic bubble, logic [1:0] a, logic [1:0] b,
                              logic exv);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.fl = fl; v.hd = hd;
    v.stall = stall; v.bubble = bubble; v.a = a; v.b = b; v.exv = exv;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid     = v.valid;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_use_rs1   = v.u1;
    bus.id_use_rs2   = v.u2;
    bus.id_rd        = v.rd;
    bus.id_reg_write = v.rw;
    bus.id_mem_read  = v.mr;
    bus.flush_in     = v.fl;
    bus.hold_in      = v.hd;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    check("stall_id", idx, 32'(bus.stall_id), 32'(v.stall));
    check("bubble_ex", idx, 32'(bus.bubble_ex), 32'(v.bubble));
    sbq.push_back('{a: v.a, b: v.b, exv: v.exv});
    if (!v.hd && v.stall) exp_stall_cnt++;
    if (!v.hd && !v.bubble && (v.a != 2'd0 || v.b != 2'd0)) exp_fwd_cnt++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("SelFwA", idx, 32'(bus.SelFwA), 32'(e.a));
    check("SelFwB", idx, 32'(bus.SelFwB), 32'(e.b));
    check("ex_valid", idx, 32'(bus.ex_valid), 32'(e.exv));
  endtask

  initial begin
    //          vld rs1 rs2 u1 u2 rd rw mr fl hd  st bb  A  B  exv
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // add x5
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1)); // sub x6,x5,x7
    tbl.push_back(mk(1, 8, 5, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 2, 1)); // x5 dist 2
    tbl.push_back(mk(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 0, 0, 3, 3, 1)); // x5 dist 3, rs1==rs2
    tbl.push_back(mk(1, 5, 6, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 3, 1)); // x5 dist 4
    tbl.push_back(mk(1, 11, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(1, 11, 11, 1, 0, 12, 1, 0, 0, 0, 0, 0, 1, 0, 1)); // nearest wins, rs2 unused
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // ld x5
    tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0)); // load-use stall
    tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2, 2, 1)); // retry -> Fw2
    tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // write x0
    tbl.push_back(mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // read x0
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // ld x0
    tbl.push_back(mk(1, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1)); // use x0: no stall
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // ld x5
    tbl.push_back(mk(1, 5, 0, 1, 0, 6, 1, 0, 1, 0, 0, 1, 0, 0, 0)); // load-use + flush
    tbl.push_back(mk(1, 5, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 2, 3, 1));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(1, 9, 5, 1, 1, 10, 1, 0, 1, 1, 1, 0, 2, 3, 1)); // held, flush ignored
    end
    tbl.push_back(mk(1, 9, 5, 1, 1, 10, 1, 0, 0, 0, 0, 0, 1, 3, 1)); // tags were frozen
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // no instr
    tbl.push_back(mk(1, 1, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // ld x4
    tbl.push_back(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0)); // load-use on rs2
    tbl.push_back(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // ld x7
    tbl.push_back(mk(1, 3, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1)); // rs2 matches load, unused

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("rst_SelFwA", 0, 32'(bus.SelFwA), 32'd0);
    check("rst_SelFwB", 0, 32'(bus.SelFwB), 32'd0);
    check("rst_ex_valid", 0, 32'(bus.ex_valid), 32'd0);
    check("rst_stall_id", 0, 32'(bus.stall_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt", 0, bus.stall_cnt, 32'(exp_stall_cnt));
    check("fwd_cnt", 0, bus.fwd_cnt, 32'(exp_fwd_cnt));
`endif

    // Reset mid-stream: load in EX, forwarded select live, consumer stalling.
    apply(mk(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 3, 0, 1), 100);
    @(negedge clk);
    drive(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    #1;
    check("pre_rst_stall_id", 101, 32'(bus.stall_id), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_SelFwA", 101, 32'(bus.SelFwA), 32'd0);
    check("mid_rst_ex_valid", 101, 32'(bus.ex_valid), 32'd0);
    check("mid_rst_stall_id", 101, 32'(bus.stall_id), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("mid_rst_stall_cnt", 101, bus.stall_cnt, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    apply(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1), 102);

    check("sb_empty", 0, 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
